// File: rtl/bcd_digit_sequencer.sv
// bcd_digit_sequencer: steps a packed BCD word out one digit at a time, MSD first, holding each digit HOLD_CYCLES clocks; optional leading-zero blanking under BLANK_LEADING_ZERO_EN.
module bcd_digit_sequencer #(
    parameter int NUM_DIGITS  = 6,
    parameter int HOLD_CYCLES = 4,
    parameter int IDX_W       = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [4*NUM_DIGITS-1:0] bcd_word,
    output logic                    enable,
    output logic [3:0]              bcd_num,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    bcd_err
);
    localparam int W = 4 * NUM_DIGITS;
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
    state_t           state_q, state_d;
    logic [W-1:0]     shadow_q, shadow_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
    logic [3:0]       bcd_num_q, bcd_num_d;
    logic             enable_q, enable_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bcd_err_q, bcd_err_d;
    logic [3:0]       load_digit;
    logic [IDX_W-1:0] load_idx;
    logic             load_en;
    logic             load_err;
    logic             hold_last;
    logic             idx_last;
`ifdef BLANK_LEADING_ZERO_EN
    logic             lead_q, lead_d;
    logic             lead_in;
`endif
    // Digit about to be presented: word MSD on start, otherwise the shadow's top nibble.
    always_comb begin
        load_digit = (state_q == IDLE) ? bcd_word[W-1 -: 4] : shadow_q[W-1 -: 4];
        load_idx   = (state_q == IDLE) ? '0 : digit_idx_q + 1'b1;
        load_err   = load_digit > 4'd9;
        hold_last  = hold_cnt_q == 8'(HOLD_CYCLES - 1);
        idx_last   = digit_idx_q == IDX_W'(NUM_DIGITS - 1);
`ifdef BLANK_LEADING_ZERO_EN
        lead_in    = (state_q == IDLE) ? 1'b1 : lead_q;
        load_en    = !load_err && !(lead_in && load_digit == 4'd0 && load_idx != IDX_W'(NUM_DIGITS - 1));
`else
        load_en    = !load_err;
`endif
    end
    // Next-state and next-output computation for the IDLE/EMIT/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        hold_cnt_d  = hold_cnt_q;
        digit_idx_d = digit_idx_q;
        bcd_num_d   = bcd_num_q;
        enable_d    = enable_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bcd_err_d   = bcd_err_q;
`ifdef BLANK_LEADING_ZERO_EN
        lead_d      = lead_q;
`endif
        if (state_q == IDLE && start && !abort) begin
            state_d     = EMIT;
            shadow_d    = bcd_word << 4;
            hold_cnt_d  = '0;
            digit_idx_d = '0;
            bcd_num_d   = load_digit;
            enable_d    = load_en;
            busy_d      = 1'b1;
            bcd_err_d   = load_err;
`ifdef BLANK_LEADING_ZERO_EN
            lead_d      = load_digit == 4'd0;
`endif
        end else if (state_q == EMIT && abort) begin
            state_d     = IDLE;
            hold_cnt_d  = '0;
            digit_idx_d = '0;
            bcd_num_d   = '0;
            enable_d    = 1'b0;
            busy_d      = 1'b0;
        end else if (state_q == EMIT && hold_last && idx_last) begin
            state_d     = DONE;
            hold_cnt_d  = '0;
            enable_d    = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
        end else if (state_q == EMIT && hold_last) begin
            shadow_d    = shadow_q << 4;
            hold_cnt_d  = '0;
            digit_idx_d = load_idx;
            bcd_num_d   = load_digit;
            enable_d    = load_en;
            bcd_err_d   = bcd_err_q | load_err;
`ifdef BLANK_LEADING_ZERO_EN
            lead_d      = lead_q && load_digit == 4'd0;
`endif
        end else if (state_q == EMIT) begin
            hold_cnt_d  = hold_cnt_q + 8'd1;
        end else if (state_q == DONE) begin
            state_d     = IDLE;
        end
    end
    // All state and outputs registered; synchronous active-low reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            hold_cnt_q  <= '0;
            digit_idx_q <= '0;
            bcd_num_q   <= '0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bcd_err_q   <= 1'b0;
`ifdef BLANK_LEADING_ZERO_EN
            lead_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            hold_cnt_q  <= hold_cnt_d;
            digit_idx_q <= digit_idx_d;
            bcd_num_q   <= bcd_num_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bcd_err_q   <= bcd_err_d;
`ifdef BLANK_LEADING_ZERO_EN
            lead_q      <= lead_d;
`endif
        end
    end
    assign enable    = enable_q;
    assign bcd_num   = bcd_num_q;
    assign digit_idx = digit_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bcd_err   = bcd_err_q;
endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// tb_bcd_digit_sequencer: randomized and directed checks of bcd_digit_sequencer against a per-slot reference model.
module tb_bcd_digit_sequencer;
    localparam int N = 6;
    localparam int H = 4;
    localparam int IW = 3;
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [4*N-1:0] bcd_word = '0;
    logic          enable;
    logic [3:0]    bcd_num;
    logic [IW-1:0] digit_idx;
    logic          busy;
    logic          done;
    logic          bcd_err;
    int            checks = 0;
    int            failures = 0;

    bcd_digit_sequencer #(.NUM_DIGITS(N), .HOLD_CYCLES(H), .IDX_W(IW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .bcd_word(bcd_word),
        .enable(enable), .bcd_num(bcd_num), .digit_idx(digit_idx), .busy(busy),
        .done(done), .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [3:0] dig(input logic [4*N-1:0] w, input int i);
        return 4'((w >> (4 * (N - 1 - i))) & 'hF);
    endfunction

    function automatic logic exp_err(input logic [4*N-1:0] w, input int i);
        for (int j = 0; j <= i; j++) if (dig(w, j) > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_en(input logic [4*N-1:0] w, input int i);
        logic all_zero;
        if (dig(w, i) > 4'd9) return 1'b0;
        all_zero = 1'b1;
        for (int j = 0; j <= i; j++) if (dig(w, j) != 4'd0) all_zero = 1'b0;
`ifdef BLANK_LEADING_ZERO_EN
        if (all_zero && i != N - 1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // kind: 0 = run to completion, 1 = abort at EMIT cycle 'at', 2 = reset at EMIT cycle 'at'
    task automatic run_word(input logic [4*N-1:0] w, input int kind, input int at, input bit scramble);
        int idx;
        bcd_word = w;
        start = 1'b1;
        abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < N * H; k++) begin
            idx = k / H;
            check("busy", 32'(busy), 32'(1'b1));
            check("idx", 32'(digit_idx), 32'(idx));
            check("num", 32'(bcd_num), 32'(dig(w, idx)));
            check("en", 32'(enable), 32'(exp_en(w, idx)));
            check("done_low", 32'(done), 32'(1'b0));
            check("err", 32'(bcd_err), 32'(exp_err(w, idx)));
            start = ($urandom_range(0, 3) == 0);
            if (scramble) bcd_word = 24'h999999 ^ 24'($urandom_range(0, 1));
            if (kind == 1 && k == at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                check("ab_busy", 32'(busy), 32'(1'b0));
                check("ab_en", 32'(enable), 32'(1'b0));
                check("ab_idx", 32'(digit_idx), 32'(0));
                check("ab_num", 32'(bcd_num), 32'(0));
                check("ab_done", 32'(done), 32'(1'b0));
                check("ab_err", 32'(bcd_err), 32'(exp_err(w, idx)));
                @(negedge clk);
                check("ab_idle", 32'({busy, done}), 32'(0));
                return;
            end
            if (kind == 2 && k == at) begin
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                start = 1'b0;
                check("rst_outs", 32'({enable, bcd_num, digit_idx, busy, done, bcd_err}), 32'(0));
                @(negedge clk);
                check("rst_idle", 32'({busy, done}), 32'(0));
                return;
            end
            @(negedge clk);
        end
        check("done", 32'(done), 32'(1'b1));
        check("done_busy", 32'(busy), 32'(1'b0));
        check("done_en", 32'(enable), 32'(1'b0));
        check("done_err", 32'(bcd_err), 32'(exp_err(w, N - 1)));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_done", 32'(done), 32'(1'b0));
        check("post_busy", 32'(busy), 32'(1'b0));
    endtask

    initial begin
        logic [4*N-1:0] w;
        int kind;
        repeat (2) @(negedge clk);
        check("rst_outs", 32'({enable, bcd_num, digit_idx, busy, done, bcd_err}), 32'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'(1'b0));
        run_word(24'h123456, 0, 0, 1'b0);
        run_word(24'h12A456, 0, 0, 1'b0);
        check("err_sticky", 32'(bcd_err), 32'(1'b1));
        run_word(24'h000000, 0, 0, 1'b0);
        run_word(24'h123456, 1, 9, 1'b0);
        run_word(24'h654321, 0, 0, 1'b0);
        run_word(24'h123456, 2, 13, 1'b0);
        run_word(24'h235959, 0, 0, 1'b1);
        run_word(24'h000507, 0, 0, 1'b0);
        run_word(24'h000000, 0, 0, 1'b0);
        run_word(24'h0F0000, 1, 2, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'(1'b0));
        check("start_abort_en", 32'(enable), 32'(1'b0));
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < N; i++) begin
                kind = $urandom_range(0, 99);
                w[4*(N-1-i) +: 4] = (kind < 25) ? 4'd0 : (kind < 35) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            kind = $urandom_range(0, 9);
            run_word(w, (kind < 2) ? 1 : (kind < 3) ? 2 : 0, $urandom_range(0, N * H - 1), 1'b0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
